// File: rtl/keypad_emulator_if.sv
// Request/status bundle between a press sequencer (master) and the keypad emulator (slave).
interface keypad_emulator_if;
    logic        key_req;
    logic [3:0]  key_code;
    logic [15:0] hold_cycles;
    logic        abort;
    logic        ready;
    logic        busy;
    logic        done;
    logic [7:0]  press_count;

    modport master (
        output key_req, key_code, hold_cycles, abort,
        input  ready, busy, done, press_count
    );

    modport slave (
        input  key_req, key_code, hold_cycles, abort,
        output ready, busy, done, press_count
    );
endinterface

// File: rtl/keypad_emulator.sv
// Matrix keypad switch model: bounced press, timed hold, bounced release, returned on
// the row line of the latched key whenever its column is driven.
module keypad_emulator #(
    parameter int BOUNCE_TOGGLES = 4,
    parameter int BOUNCE_PERIOD  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         col,
    output logic [3:0]         R,
    output logic               contact,
    keypad_emulator_if.slave   bus
);
    localparam int DW = (BOUNCE_PERIOD > 1) ? $clog2(BOUNCE_PERIOD) : 1;

    typedef enum logic [2:0] {
        IDLE,
        BOUNCE_PRESS,
        HOLD,
        BOUNCE_RELEASE,
        DONE
    } state_t;

    state_t      state_reg, state_next;
    logic [4:0]  phase_reg, phase_next;
    logic [DW-1:0] div_reg, div_next;
    logic [15:0] hold_reg, hold_next;
    logic [15:0] hold_len_reg, hold_len_next;
    logic [3:0]  code_reg, code_next;
    logic [7:0]  count_reg, count_next;
    logic        contact_reg, contact_next;
    logic        phase_end;
    logic        last_phase;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            phase_reg    <= '0;
            div_reg      <= '0;
            hold_reg     <= '0;
            hold_len_reg <= '0;
            code_reg     <= '0;
            count_reg    <= '0;
            contact_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            phase_reg    <= phase_next;
            div_reg      <= div_next;
            hold_reg     <= hold_next;
            hold_len_reg <= hold_len_next;
            code_reg     <= code_next;
            count_reg    <= count_next;
            contact_reg  <= contact_next;
        end
    end

    assign phase_end  = (div_reg == DW'(BOUNCE_PERIOD - 1));
    assign last_phase = (phase_reg == 5'(BOUNCE_TOGGLES));

    always_comb begin
        state_next    = state_reg;
        phase_next    = phase_reg;
        div_next      = div_reg;
        hold_next     = hold_reg;
        hold_len_next = hold_len_reg;
        code_next     = code_reg;
        count_next    = count_reg;
        contact_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.key_req) begin
                    state_next    = BOUNCE_PRESS;
                    phase_next    = '0;
                    div_next      = '0;
                    code_next     = bus.key_code;
                    hold_len_next = (bus.hold_cycles == 16'd0) ? 16'd1 : bus.hold_cycles;
                end
            end
            BOUNCE_PRESS: begin
                if (phase_end) begin
                    div_next = '0;
                    if (last_phase) begin
                        state_next = HOLD;
                        phase_next = '0;
                        hold_next  = hold_len_reg;
                    end else begin
                        phase_next = phase_reg + 5'd1;
                    end
                end else begin
                    div_next = div_reg + DW'(1);
                end
            end
            HOLD: begin
                // Down-counter loaded with the latched length; leaves on the last closed cycle.
                if (hold_reg <= 16'd1) begin
                    state_next = BOUNCE_RELEASE;
                    phase_next = '0;
                    div_next   = '0;
                    hold_next  = '0;
                end else begin
                    hold_next = hold_reg - 16'd1;
                end
            end
            BOUNCE_RELEASE: begin
                if (phase_end) begin
                    div_next = '0;
                    if (last_phase) begin
                        state_next = DONE;
                        phase_next = '0;
                    end else begin
                        phase_next = phase_reg + 5'd1;
                    end
                end else begin
                    div_next = div_reg + DW'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
                count_next = count_reg + 8'd1;
            end
            default: state_next = IDLE;
        endcase

        if (bus.abort && (state_reg != IDLE)) begin
            state_next = IDLE;
            phase_next = '0;
            div_next   = '0;
            hold_next  = '0;
        end

        // Contact is registered, so derive it from where the FSM is going next.
        case (state_next)
            BOUNCE_PRESS:   contact_next = ~phase_next[0];
            HOLD:           contact_next = 1'b1;
            BOUNCE_RELEASE: contact_next = phase_next[0];
            default:        contact_next = 1'b0;
        endcase
    end

    assign contact         = contact_reg;
    assign bus.ready       = (state_reg == IDLE);
    assign bus.busy        = (state_reg != IDLE);
    assign bus.done        = (state_reg == DONE);
    assign bus.press_count = count_reg;

    for (genvar gi = 0; gi < 4; gi++) begin : g_row
        assign R[gi] = contact_reg & col[code_reg[1:0]] & (code_reg[3:2] == 2'(gi));
    end
endmodule
